// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit for the execution stage.
// Accepts one operation on start, stalls the pipeline while it iterates for 32
// cycles on operand magnitudes, applies sign correction, then presents the
// result for a single cycle with done. Divide-by-zero and signed overflow
// bypass the iteration and complete on the accept edge.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [5:0]      LAST_IT  = 6'(XLEN - 1);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            neg_q, neg_d;          // product / quotient must be negated
  logic            rem_neg_q, rem_neg_d;  // remainder takes the dividend sign
  logic [XLEN-1:0] hi_q, hi_d;            // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;            // multiplier then product low / dividend then quotient
  logic [XLEN-1:0] mcand_q, mcand_d;      // multiplicand or divisor magnitude
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  // Accept-side decode: operand signedness, magnitudes and the special divide cases.
  op_e             op_in;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_by_zero, div_ovf;
  logic [XLEN-1:0] special_val;

  always_comb begin
    op_in       = op_e'(op);
    a_signed    = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                  (op_in == OP_DIV) || (op_in == OP_REM);
    b_signed    = (op_in == OP_MUL) || (op_in == OP_MULH) ||
                  (op_in == OP_DIV) || (op_in == OP_REM);
    a_neg       = a_signed && a[XLEN-1];
    b_neg       = b_signed && b[XLEN-1];
    mag_a       = a_neg ? -a : a;
    mag_b       = b_neg ? -b : b;
    div_by_zero = op[2] && (b == '0);
    div_ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) && (a == INT_MIN) && (&b);
    // op[1] separates REM/REMU from DIV/DIVU within the divide group.
    if (div_by_zero) special_val = op[1] ? a : '1;
    else             special_val = op[1] ? '0 : INT_MIN;
  end

  // One iteration step for both algorithms, plus the sign-corrected final values.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_bit;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    // A clear borrow bit means the shifted remainder covered the divisor.
    div_bit   = ~div_diff[XLEN];
    prod      = {hi_q, lo_q};
    prod_fix  = neg_q ? -prod : prod;
    quo_fix   = neg_q ? -lo_q : lo_q;
    rem_fix   = rem_neg_q ? -hi_q : hi_q;
    unique case (op_q)
      OP_MUL:                       fix_val = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_val = quo_fix;
      default:                      fix_val = rem_fix;
    endcase
  end

  // Sequencer next-state and datapath next-value logic.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    result_d  = result_q;

    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d      = op_in;
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          cnt_d     = '0;
          if (div_by_zero || div_ovf) begin
            result_d = special_val;
            state_d  = DONE;
          end else begin
            hi_d    = '0;
            lo_d    = op[2] ? mag_a : mag_b;
            mcand_d = op[2] ? mag_b : mag_a;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (op_q[2]) begin
          hi_d = div_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], div_bit};
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == LAST_IT) state_d = FIX;
        else                  cnt_d   = cnt_q + 6'd1;
      end
      FIX: begin
        result_d = fix_val;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase

    // An abort discards the operation and leaves the last result untouched.
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  // Registered status outputs follow the state being entered.
  always_comb begin
    done_d = (state_d == DONE);
    busy_d = (state_d == CALC) || (state_d == FIX);
  end

  // State and datapath registers; reset clears everything, including the datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      result_q  <= result_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // The stall must rise in the request cycle itself, so it decodes state and inputs.
  assign stall  = ((state_q == IDLE) && start && !flush) || (state_q == CALC) || (state_q == FIX);
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
